drygascon128_hash_ctrl: RTL and testbench

- Sequencer that runs a complete DryGASCON128 hash on the drygascon128 core's command interface.
- On a start command it:
  - loads the C and X initial state;
  - absorbs a byte stream as 16-byte blocks, applying padding and domain separation;
  - runs the final f and g calls;
  - streams out the 32-byte digest.
- Sits between a host-side message stream and one core instance, and owns that core exclusively.

---
 rtl/drygascon128_hash_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_drygascon128_hash_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/drygascon128_hash_ctrl.sv
// drygascon128_hash_ctrl
// Runs one complete DryGASCON128 hash on a drygascon128 core that this block
// owns. The sequence is: load C and X, absorb the message as 16-byte blocks
// (padding and domain separation are applied here), run the final f and g
// calls, and stream out the 32-byte digest.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   cmd_start, busy         start pulse (taken only when idle) / hash in progress
//   msg_valid/ready/data/last/bytes
//                           host message stream, little-endian, 0..4 bytes/word
//   dig_valid/ready/data    digest stream, 8 words, word 0 = digest bytes 0..3
//   core_din, core_ds, core_rounds, core_wr_c/x/i, core_start, core_rd_r
//                           core command interface
//   core_dout, core_idle    core R read data (one cycle after rd_r) / idle
module drygascon128_hash_ctrl #(
  // Defaults are hex digits of pi. Override them with the hash initial state
  // in the core's word order.
  parameter logic [319:0] INIT_C  = 320'h243F6A88_85A308D3_13198A2E_03707344_A4093822_299F31D0_082EFA98_EC4E6C89_452821E6_38D01377,
  parameter logic [127:0] INIT_X  = 128'hBE5466CF_34E90C6C_C0AC29B7_C97C50DD,
  parameter logic [3:0]   ROUNDS  = 4'd7,
  parameter logic [1:0]   DS_HASH = 2'd2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_start,
  output logic        busy,
  input  logic        msg_valid,
  output logic        msg_ready,
  input  logic [31:0] msg_data,
  input  logic        msg_last,
  input  logic [2:0]  msg_bytes,
  output logic        dig_valid,
  input  logic        dig_ready,
  output logic [31:0] dig_data,
  output logic [31:0] core_din,
  output logic [3:0]  core_ds,
  output logic [3:0]  core_rounds,
  output logic        core_wr_c,
  output logic        core_wr_x,
  output logic        core_wr_i,
  output logic        core_start,
  output logic        core_rd_r,
  input  logic [31:0] core_dout,
  input  logic        core_idle
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD_C, S_LOAD_X, S_COLLECT, S_WR_I, S_START, S_WAIT,
    S_RD_R, S_G_START, S_G_WAIT, S_G_RD, S_OUT
  } state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  // 20 bytes: a word written at offset 15 may spill up to 3 bytes past the
  // 16-byte block; the spill is shifted down after the block is absorbed.
  logic [159:0]   buf_q, buf_d;
  logic [4:0]     fill_q, fill_d;
  logic           last_q, last_d;
  logic           final_q, final_d;
  logic [3:0]     ds_q, ds_d;
  logic [255:0]   dig_q;
  logic           rd_vld_q;
  logic [2:0]     rd_idx_q;
  logic [2:0]     nb;

  assign core_rounds = ROUNDS;
  assign core_ds     = ds_q;
  assign nb          = (msg_bytes > 3'd4) ? 3'd4 : msg_bytes;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    fill_d     = fill_q;
    last_d     = last_q;
    final_d    = final_q;
    ds_d       = ds_q;
    busy       = (state_q != S_IDLE);
    msg_ready  = 1'b0;
    dig_valid  = 1'b0;
    dig_data   = 32'h0;
    core_din   = 32'h0;
    core_wr_c  = 1'b0;
    core_wr_x  = 1'b0;
    core_wr_i  = 1'b0;
    core_start = 1'b0;
    core_rd_r  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          state_d = S_LOAD_C;
          cnt_d   = 4'd0;
          buf_d   = '0;
          fill_d  = 5'd0;
          last_d  = 1'b0;
          final_d = 1'b0;
        end
      end
      S_LOAD_C: begin
        core_wr_c = 1'b1;
        core_din  = INIT_C[{cnt_q, 5'b0} +: 32];
        if (cnt_q == 4'd9) begin
          cnt_d   = 4'd0;
          state_d = S_LOAD_X;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_LOAD_X: begin
        core_wr_x = 1'b1;
        core_din  = INIT_X[{cnt_q[1:0], 5'b0} +: 32];
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          state_d = S_COLLECT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_COLLECT: begin
        cnt_d = 4'd0;
        if (fill_q >= 5'd16) begin
          // Full block: final (unpadded) only if the message ends exactly here.
          final_d = last_q && (fill_q == 5'd16);
          ds_d    = {DS_HASH, last_q && (fill_q == 5'd16), 1'b0};
          state_d = S_WR_I;
        end else if (last_q) begin
          // Bytes past fill are already zero, so only the 0x01 marker is added.
          buf_d[{fill_q, 3'b000} +: 8] = 8'h01;
          final_d = 1'b1;
          ds_d    = {DS_HASH, 2'b11};
          state_d = S_WR_I;
        end else begin
          msg_ready = 1'b1;
          if (msg_valid) begin
            for (int k = 0; k < 4; k++) begin
              if (3'(k) < nb) buf_d[{fill_q + 5'(k), 3'b000} +: 8] = msg_data[8*k +: 8];
            end
            fill_d = fill_q + {2'b00, nb};
            last_d = msg_last;
          end
        end
      end
      S_WR_I: begin
        core_wr_i = 1'b1;
        core_din  = buf_q[{1'b0, cnt_q[1:0], 5'b0} +: 32];
        if (cnt_q == 4'd3) state_d = S_START;
        cnt_d = cnt_q + 4'd1;
      end
      S_START, S_G_START: begin
        core_start = 1'b1;
        cnt_d      = 4'd0;
        state_d    = (state_q == S_START) ? S_WAIT : S_G_WAIT;
      end
      S_WAIT, S_G_WAIT: begin
        // core_idle may still show the previous idle level right after start.
        if (cnt_q == 4'd0) begin
          cnt_d = 4'd1;
        end else if (core_idle) begin
          cnt_d = 4'd0;
          if (state_q == S_G_WAIT) begin
            state_d = S_G_RD;
          end else if (final_q) begin
            state_d = S_RD_R;
          end else begin
            buf_d   = {128'h0, buf_q[159:128]};
            fill_d  = fill_q - 5'd16;
            state_d = S_COLLECT;
          end
        end
      end
      S_RD_R, S_G_RD: begin
        core_rd_r = 1'b1;
        if (cnt_q == 4'd3) begin
          cnt_d   = 4'd0;
          state_d = (state_q == S_RD_R) ? S_G_START : S_OUT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_OUT: begin
        dig_valid = 1'b1;
        dig_data  = dig_q[{cnt_q[2:0], 5'b0} +: 32];
        if (dig_ready) begin
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'd7) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      buf_q    <= '0;
      fill_q   <= 5'd0;
      last_q   <= 1'b0;
      final_q  <= 1'b0;
      ds_q     <= 4'd0;
      dig_q    <= '0;
      rd_vld_q <= 1'b0;
      rd_idx_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      buf_q    <= buf_d;
      fill_q   <= fill_d;
      last_q   <= last_d;
      final_q  <= final_d;
      ds_q     <= ds_d;
      // R data arrives one cycle after the read strobe.
      rd_vld_q <= core_rd_r;
      rd_idx_q <= {state_q == S_G_RD, cnt_q[1:0]};
      if (rd_vld_q) dig_q[{rd_idx_q, 5'b0} +: 32] <= core_dout;
    end
  end

endmodule

// File: tb/tb_drygascon128_hash_ctrl.sv
// Bench for drygascon128_hash_ctrl with a behavioural stand-in core: fixed
// busy time after start, and R words derived from a running mix of every word
// and domain separator the core receives.
module tb_drygascon128_hash_ctrl;
  localparam logic [319:0] TB_C = 320'hC0DE0009_C0DE0008_C0DE0007_C0DE0006_C0DE0005_C0DE0004_C0DE0003_C0DE0002_C0DE0001_C0DE0000;
  localparam logic [127:0] TB_X = 128'hA11C0003_A11C0002_A11C0001_A11C0000;
  localparam logic [31:0]  SEED = 32'h6A09E667;
  localparam logic [31:0]  KJ   = 32'h9E3779B9;

  logic        clk = 1'b0;
  logic        reset_n, cmd_start, busy;
  logic        msg_valid, msg_ready, msg_last;
  logic [31:0] msg_data;
  logic [2:0]  msg_bytes;
  logic        dig_valid, dig_ready;
  logic [31:0] dig_data, core_din, core_dout;
  logic [3:0]  core_ds, core_rounds;
  logic        core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r, core_idle;

  always #5 clk = ~clk;

  drygascon128_hash_ctrl #(.INIT_C(TB_C), .INIT_X(TB_X), .ROUNDS(4'd7), .DS_HASH(2'd2)) dut (
    .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .busy(busy),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_last(msg_last), .msg_bytes(msg_bytes),
    .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data),
    .core_din(core_din), .core_ds(core_ds), .core_rounds(core_rounds),
    .core_wr_c(core_wr_c), .core_wr_x(core_wr_x), .core_wr_i(core_wr_i),
    .core_start(core_start), .core_rd_r(core_rd_r),
    .core_dout(core_dout), .core_idle(core_idle)
  );

  typedef struct packed { logic [127:0] w; logic [3:0] ds; } blk_t;

  blk_t        blk_exp[$];
  logic [31:0] dig_exp[$];
  int          n_checks = 0, n_errors = 0;

  logic [31:0] m_data[8];
  logic [2:0]  m_nb[8];
  int          m_n, m_nblk;
  blk_t        m_blk[2];

  // stand-in core state
  logic [31:0]  acc;
  logic [127:0] cur_i;
  bit           prev_wrc, wri_seen, rd_pend;
  int           c_idx, x_idx, i_idx, busy_cnt, rd_cnt;
  int           n_wrc = 0, n_wrx = 0, n_wri = 0, n_start = 0, n_rdr = 0;

  // digest monitor / backpressure state
  bit          hold_prev, stall_en;
  logic [31:0] prev_data;
  int          dig_cnt = 0, dig_base = 0, stalls = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] mixw(input logic [31:0] a, input logic [31:0] w);
    return {a[26:0], a[31:27]} ^ w;
  endfunction

  task automatic core_model();
    blk_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rd_pend = 0; busy_cnt = 0; core_idle = 1'b1; wri_seen = 0; i_idx = 0; prev_wrc = 0;
      end else begin
        if (rd_pend) begin
          core_dout = acc ^ (KJ * 32'(rd_cnt));
          rd_cnt++;
        end
        rd_pend = core_rd_r;
        if (core_rd_r) n_rdr++;
        if (core_wr_c) begin
          if (!prev_wrc) begin acc = SEED; c_idx = 0; x_idx = 0; rd_cnt = 0; end
          check("wr_c_word", core_din, TB_C[c_idx*32 +: 32]);
          acc = mixw(acc, core_din);
          c_idx++; n_wrc++;
        end
        prev_wrc = core_wr_c;
        if (core_wr_x) begin
          check("wr_x_word", core_din, TB_X[x_idx*32 +: 32]);
          acc = mixw(acc, core_din);
          x_idx++; n_wrx++;
        end
        if (core_wr_i) begin
          if (i_idx < 4) cur_i[i_idx*32 +: 32] = core_din;
          acc = mixw(acc, core_din);
          i_idx++; n_wri++; wri_seen = 1;
        end
        if (core_start) begin
          n_start++;
          check("rounds", {28'h0, core_rounds}, 32'd7);
          if (wri_seen) begin
            if (blk_exp.size() == 0) fail_now("unexpected_block");
            else begin
              e = blk_exp.pop_front();
              for (int k = 0; k < 4; k++) check("blk_i_word", cur_i[k*32 +: 32], e.w[k*32 +: 32]);
              check("blk_ds", {28'h0, core_ds}, {28'h0, e.ds});
            end
            acc = mixw(acc, {28'h0, core_ds});
          end else begin
            acc = mixw(acc, 32'hFFFF0000 | {28'h0, core_ds});
          end
          wri_seen = 0; i_idx = 0; busy_cnt = 3;
        end else if (busy_cnt > 0) begin
          busy_cnt--;
        end
        core_idle = (busy_cnt == 0);
      end
    end
  endtask

  task automatic dig_monitor();
    forever begin
      @(negedge clk);
      if (reset_n && dig_valid) begin
        if (hold_prev) check("dig_hold", dig_data, prev_data);
        if (dig_ready) begin
          if (dig_exp.size() == 0) fail_now("unexpected_digest_word");
          else check("dig_word", dig_data, dig_exp.pop_front());
          dig_cnt++;
          hold_prev = 0;
        end else begin
          hold_prev = 1;
          prev_data = dig_data;
        end
      end else begin
        hold_prev = 0;
      end
    end
  endtask

  task automatic stall_driver();
    forever begin
      @(posedge clk); #1;
      if (stall_en && dig_valid && (dig_cnt - dig_base == 3) && stalls < 5) begin
        dig_ready = 1'b0;
        stalls++;
      end else begin
        dig_ready = 1'b1;
      end
    end
  endtask

  task automatic set_blk(input int idx, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3, input logic [3:0] ds);
    m_blk[idx].w  = {w3, w2, w1, w0};
    m_blk[idx].ds = ds;
  endtask

  task automatic set_word(input int idx, input logic [31:0] d, input logic [2:0] nb);
    m_data[idx] = d;
    m_nb[idx]   = nb;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input bit last);
    int t = 0;
    msg_valid = 1'b1; msg_data = d; msg_bytes = nb; msg_last = last;
    forever begin
      @(negedge clk);
      if (msg_ready) break;
      t++;
      if (t > 500) begin fail_now("msg_ready_timeout"); break; end
    end
    @(posedge clk); #1;
    msg_valid = 1'b0; msg_data = '0; msg_bytes = '0; msg_last = 1'b0;
  endtask

  task automatic pulse_start();
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic run_hash(input string tag, input bit stall);
    logic [31:0] a;
    int s_c, s_x, s_i, s_s, s_r, t;
    a = SEED;
    for (int i = 0; i < 10; i++) a = mixw(a, TB_C[i*32 +: 32]);
    for (int i = 0; i < 4; i++) a = mixw(a, TB_X[i*32 +: 32]);
    for (int b = 0; b < m_nblk; b++) begin
      for (int k = 0; k < 4; k++) a = mixw(a, m_blk[b].w[k*32 +: 32]);
      a = mixw(a, {28'h0, m_blk[b].ds});
      blk_exp.push_back(m_blk[b]);
    end
    for (int j = 0; j < 4; j++) dig_exp.push_back(a ^ (KJ * 32'(j)));
    a = mixw(a, 32'hFFFF0000 | {28'h0, m_blk[m_nblk-1].ds});
    for (int j = 4; j < 8; j++) dig_exp.push_back(a ^ (KJ * 32'(j)));

    s_c = n_wrc; s_x = n_wrx; s_i = n_wri; s_s = n_start; s_r = n_rdr;
    stall_en = stall; stalls = 0; dig_base = dig_cnt;
    pulse_start();
    check({tag, "_busy_after_start"}, {31'h0, busy}, 32'd1);
    check({tag, "_ready_in_load"}, {31'h0, msg_ready}, 32'd0);
    for (int i = 0; i < m_n; i++) send_word(m_data[i], m_nb[i], i == m_n - 1);
    pulse_start();  // busy: must be ignored
    t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    if (busy) fail_now({tag, "_done_timeout"});
    check({tag, "_n_wr_c"}, 32'(n_wrc - s_c), 32'd10);
    check({tag, "_n_wr_x"}, 32'(n_wrx - s_x), 32'd4);
    check({tag, "_n_wr_i"}, 32'(n_wri - s_i), 32'(4 * m_nblk));
    check({tag, "_n_start"}, 32'(n_start - s_s), 32'(m_nblk + 1));
    check({tag, "_n_rd_r"}, 32'(n_rdr - s_r), 32'd8);
    check({tag, "_dig_count"}, 32'(dig_cnt - dig_base), 32'd8);
    stall_en = 0;
    @(posedge clk); #1;
  endtask

  task automatic abort_run();
    int s, t;
    blk_exp.push_back(m_blk[0]);
    s = n_start;
    pulse_start();
    send_word(32'h0, 3'd0, 1'b1);
    t = 0;
    while (n_start == s && t < 500) begin @(negedge clk); t++; end
    if (n_start == s) fail_now("abort_start_timeout");
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("abort_busy", {31'h0, busy}, 32'd0);
    check("abort_ready_valid", {30'h0, msg_ready, dig_valid}, 32'd0);
    check("abort_strobes", {27'h0, core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r}, 32'd0);
    check("abort_din", core_din, 32'd0);
    check("abort_ds", {28'h0, core_ds}, 32'd0);
    check("abort_dig_data", dig_data, 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    reset_n = 1'b0; cmd_start = 1'b0; msg_valid = 1'b0; msg_data = '0; msg_last = 1'b0;
    msg_bytes = '0; dig_ready = 1'b1; core_idle = 1'b1; core_dout = '0; stall_en = 0;
    hold_prev = 0; prev_wrc = 0; wri_seen = 0; rd_pend = 0; busy_cnt = 0; i_idx = 0;
    acc = SEED; cur_i = '0; rd_cnt = 0; c_idx = 0; x_idx = 0; prev_data = '0;
    fork
      core_model();
      dig_monitor();
      stall_driver();
    join_none
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'h0, busy}, 32'd0);
    check("rst_ready_valid", {30'h0, msg_ready, dig_valid}, 32'd0);
    check("rst_strobes", {27'h0, core_wr_c, core_wr_x, core_wr_i, core_start, core_rd_r}, 32'd0);
    check("rst_din_ds", {core_din[27:0], core_ds}, 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // empty message: one padded final block 01 00..00
    m_n = 1; set_word(0, 32'h0, 3'd0);
    m_nblk = 1; set_blk(0, 32'h00000001, 32'h0, 32'h0, 32'h0, 4'hB);
    run_hash("empty", 0);

    // 8 bytes 00..07, digest word 3 stalled 5 cycles
    m_n = 2; set_word(0, 32'h03020100, 3'd4); set_word(1, 32'h07060504, 3'd4);
    m_nblk = 1; set_blk(0, 32'h03020100, 32'h07060504, 32'h00000001, 32'h0, 4'hB);
    run_hash("msg8", 1);

    // 17 bytes 00..10, aligned words
    m_n = 5;
    set_word(0, 32'h03020100, 3'd4); set_word(1, 32'h07060504, 3'd4);
    set_word(2, 32'h0B0A0908, 3'd4); set_word(3, 32'h0F0E0D0C, 3'd4);
    set_word(4, 32'h00000010, 3'd1);
    m_nblk = 2;
    set_blk(0, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 4'h8);
    set_blk(1, 32'h00000110, 32'h0, 32'h0, 32'h0, 4'hB);
    run_hash("msg17", 0);

    // same 17 bytes as 3+4+4+4+2
    set_word(0, 32'h00020100, 3'd3); set_word(1, 32'h06050403, 3'd4);
    set_word(2, 32'h0A090807, 3'd4); set_word(3, 32'h0E0D0C0B, 3'd4);
    set_word(4, 32'h0000100F, 3'd2);
    run_hash("msg17u", 0);

    // exactly 16 bytes: single unpadded final block
    m_n = 4;
    set_word(0, 32'h03020100, 3'd4); set_word(1, 32'h07060504, 3'd4);
    set_word(2, 32'h0B0A0908, 3'd4); set_word(3, 32'h0F0E0D0C, 3'd4);
    m_nblk = 1;
    set_blk(0, 32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C, 4'hA);
    run_hash("msg16", 0);

    // reset during WAIT, then the empty hash again
    m_n = 1; set_word(0, 32'h0, 3'd0);
    m_nblk = 1; set_blk(0, 32'h00000001, 32'h0, 32'h0, 32'h0, 4'hB);
    abort_run();
    run_hash("empty_again", 0);

    repeat (10) @(posedge clk);
    check("blk_queue_left", 32'(blk_exp.size()), 32'd0);
    check("dig_queue_left", 32'(dig_exp.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
